maxnet_update: RTL and testbench

//  Downstream stage of the four MaxNet processing units. Holds the neuron activation bank x0..x3, which drives every PU.

---
 rtl/maxnet_pkg.sv | 25 ++
 rtl/maxnet_update_if.sv | 38 +++
 rtl/maxnet_relu_sat.sv | 29 ++
 rtl/maxnet_update.sv | 146 ++++++++++++++
 tb/tb_maxnet_update.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/maxnet_pkg.sv
// Shared constants and types for the MaxNet activation update stage.
package maxnet_pkg;

  localparam int X_W      = 5;
  localparam int ACC_W    = 12;
  localparam int FRAC     = 3;
  localparam int PU_LAT   = 2;
  localparam int ITER_W   = 6;
  localparam int MAX_ITER = 40;
  localparam int N        = 4;

  // Largest activation representable in the signed X_W-bit bank
  localparam int X_MAX    = (1 << (X_W - 1)) - 1;

  // Wait counter sized to hold 0..PU_LAT
  localparam int WAIT_W   = $clog2(PU_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/maxnet_update_if.sv
// Bus between the MaxNet update stage and its environment (start/load,
// PU results in, activation bank and status out). The timeout line exists
// only when MAXNET_TIMEOUT_EN is defined.
interface maxnet_update_if;
  import maxnet_pkg::*;

  logic                    start;
  logic signed [X_W-1:0]   x0_in, x1_in, x2_in, x3_in;
  logic signed [ACC_W-1:0] pu_out0, pu_out1, pu_out2, pu_out3;
  logic signed [X_W-1:0]   x0, x1, x2, x3;
  logic                    busy;
  logic                    done;
  logic [1:0]              winner;
  logic                    winner_valid;
  logic [ITER_W-1:0]       iter_cnt;
`ifdef MAXNET_TIMEOUT_EN
  logic                    timeout;
`endif

  modport master (
    output start, x0_in, x1_in, x2_in, x3_in,
    output pu_out0, pu_out1, pu_out2, pu_out3,
    input  x0, x1, x2, x3, busy, done, winner, winner_valid, iter_cnt
`ifdef MAXNET_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  start, x0_in, x1_in, x2_in, x3_in,
    input  pu_out0, pu_out1, pu_out2, pu_out3,
    output x0, x1, x2, x3, busy, done, winner, winner_valid, iter_cnt
`ifdef MAXNET_TIMEOUT_EN
    , output timeout
`endif
  );

endinterface

// File: rtl/maxnet_relu_sat.sv
// Folds one PU sum back to an activation: ReLU, drop FRAC fraction bits
// (truncating), then clamp to the largest positive activation.
module maxnet_relu_sat
  import maxnet_pkg::*;
(
  input  logic signed [ACC_W-1:0] s_i,
  output logic signed [X_W-1:0]   x_o
);

  localparam logic signed [ACC_W-1:0] SAT_ACC = ACC_W'(X_MAX);
  localparam logic signed [X_W-1:0]   SAT_X   = X_W'(X_MAX);

  function automatic logic signed [X_W-1:0] relu_sat(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] q;
    q = s >>> FRAC;
    if (s <= 0)
      return '0;
    else if (q > SAT_ACC)
      return SAT_X;
    else
      return q[X_W-1:0];
  endfunction

  // Purely combinational activation function
  always_comb begin
    x_o = relu_sat(s_i);
  end

endmodule

// File: rtl/maxnet_update.sv
// MaxNet activation bank and iteration controller. Loads x on start, waits
// PU_LAT cycles for the PUs, folds the sums back into x, and repeats until
// at most one neuron remains nonzero. Optional iteration cap and timeout
// flag are enabled by defining MAXNET_TIMEOUT_EN.
module maxnet_update
  import maxnet_pkg::*;
(
  input logic            clk,
  input logic            rst,
  maxnet_update_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PU_LAT - 1);

  state_t                  state_q;
  logic [WAIT_W-1:0]       wcnt_q;
  logic signed [X_W-1:0]   x_q [N];
  logic [ITER_W-1:0]       iter_q;
  logic                    busy_q;
  logic                    done_q;
  logic [1:0]              winner_q;
  logic                    wvld_q;
`ifdef MAXNET_TIMEOUT_EN
  logic                    timeout_q;
`endif

  logic signed [X_W-1:0]   x_in [N];
  logic signed [ACC_W-1:0] pu   [N];
  logic signed [X_W-1:0]   x_d  [N];
  logic [2:0]              nz_cnt;
  logic [1:0]              win_idx;
  logic [ITER_W-1:0]       iter_d;
  logic                    converged;

  // Gather the scalar bus lanes into arrays
  always_comb begin
    x_in[0] = bus.x0_in;
    x_in[1] = bus.x1_in;
    x_in[2] = bus.x2_in;
    x_in[3] = bus.x3_in;
    pu[0]   = bus.pu_out0;
    pu[1]   = bus.pu_out1;
    pu[2]   = bus.pu_out2;
    pu[3]   = bus.pu_out3;
  end

  for (genvar g = 0; g < N; g++) begin : g_relu
    maxnet_relu_sat u_relu (
      .s_i (pu[g]),
      .x_o (x_d[g])
    );
  end

  // Survivor count and winner index of the candidate next activations
  always_comb begin
    nz_cnt  = '0;
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (x_d[i] != '0) begin
        nz_cnt  = nz_cnt + 3'd1;
        win_idx = 2'(i);
      end
    end
    converged = (nz_cnt <= 3'd1);
    iter_d    = (&iter_q) ? iter_q : iter_q + 1'b1;
  end

  // Iteration FSM with registered bank and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      for (int i = 0; i < N; i++) x_q[i] <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      winner_q <= '0;
      wvld_q   <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            for (int i = 0; i < N; i++) x_q[i] <= x_in[i];
            iter_q  <= '0;
            done_q  <= 1'b0;
            wvld_q  <= 1'b0;
            busy_q  <= 1'b1;
            wcnt_q  <= '0;
`ifdef MAXNET_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wcnt_q == WAIT_LAST) begin
            wcnt_q  <= '0;
            state_q <= ST_UPDATE;
          end else begin
            wcnt_q  <= wcnt_q + 1'b1;
          end
        end
        ST_UPDATE: begin
          for (int i = 0; i < N; i++) x_q[i] <= x_d[i];
          iter_q <= iter_d;
          if (converged) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            wvld_q   <= (nz_cnt == 3'd1);
            winner_q <= (nz_cnt == 3'd1) ? win_idx : 2'd0;
`ifdef MAXNET_TIMEOUT_EN
          end else if (({1'b0, iter_q} + 1'b1) == (ITER_W + 1)'(MAX_ITER)) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            wvld_q    <= 1'b0;
            winner_q  <= 2'd0;
            timeout_q <= 1'b1;
`endif
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.x0           = x_q[0];
  assign bus.x1           = x_q[1];
  assign bus.x2           = x_q[2];
  assign bus.x3           = x_q[3];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = wvld_q;
  assign bus.iter_cnt     = iter_q;
`ifdef MAXNET_TIMEOUT_EN
  assign bus.timeout      = timeout_q;
`endif

endmodule

// File: tb/tb_maxnet_update.sv
// Bench for maxnet_update: four PUs (w_ii = 1.0, w_ij = -0.125, two-cycle
// latency) fed back from the activation bank, directed and random runs
// checked against an iteration-level reference model.
module tb_maxnet_update;
  import maxnet_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxnet_update_if bus();

  maxnet_update u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // PU harness: product register then sum register
  logic signed [ACC_W-1:0] prod_d [N][N];
  logic signed [ACC_W-1:0] prod_q [N][N];
  logic signed [ACC_W-1:0] psum   [N];
  logic signed [ACC_W-1:0] pu_q   [N];
  logic signed [X_W-1:0]   xv     [N];
  logic                    use_model;
  int                      force_pu [N];

  assign xv[0] = bus.x0;
  assign xv[1] = bus.x1;
  assign xv[2] = bus.x2;
  assign xv[3] = bus.x3;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      psum[i] = '0;
      for (int j = 0; j < N; j++) begin
        prod_d[i][j] = ACC_W'(((i == j) ? 8 : -1) * int'(xv[j]));
        psum[i]      = psum[i] + prod_q[i][j];
      end
    end
  end

  always @(posedge clk) begin
    prod_q <= prod_d;
    pu_q   <= psum;
  end

  assign bus.pu_out0 = use_model ? pu_q[0] : ACC_W'(force_pu[0]);
  assign bus.pu_out1 = use_model ? pu_q[1] : ACC_W'(force_pu[1]);
  assign bus.pu_out2 = use_model ? pu_q[2] : ACC_W'(force_pu[2]);
  assign bus.pu_out3 = use_model ? pu_q[3] : ACC_W'(force_pu[3]);

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: activation after one MaxNet step from a real-valued view
  function automatic int f_ref(input int s);
    int q;
    if (s <= 0) return 0;
    q = s / (1 << FRAC);
    return (q > X_MAX) ? X_MAX : q;
  endfunction

  function automatic int nz_of(input int v[N]);
    int n = 0;
    foreach (v[i]) if (v[i] != 0) n++;
    return n;
  endfunction

  function automatic longint pack4(input int v[N]);
    longint r = 0;
    for (int i = 0; i < N; i++) r = r * 64 + longint'(v[i]);
    return r;
  endfunction

  function automatic longint obs_x();
    int v[N];
    for (int i = 0; i < N; i++) v[i] = int'(xv[i]);
    return pack4(v);
  endfunction

  int traj [0:63][N];

  task automatic run_case(input string name, input int xi[N], input bit forced,
                          input int pf[N], input bit inj);
    int iters, c, nz, win, tmo;
    int cur[N];
    bit seen;
    // Expected trajectory
    cur = xi;
    traj[0] = xi;
    iters = 0;
    tmo = 0;
    if (forced) begin
      for (int i = 0; i < N; i++) cur[i] = f_ref(pf[i]);
      iters = 1;
      traj[1] = cur;
    end else begin
      do begin
        int nxt[N];
        int tot = 0;
        foreach (cur[j]) tot += cur[j];
        for (int i = 0; i < N; i++) nxt[i] = f_ref(8 * cur[i] - (tot - cur[i]));
        cur = nxt;
        iters++;
        traj[iters] = cur;
`ifdef MAXNET_TIMEOUT_EN
        if (nz_of(cur) > 1 && iters == MAX_ITER) tmo = 1;
`endif
      end while (nz_of(cur) > 1 && tmo == 0 && iters < 60);
    end
    nz  = nz_of(cur);
    win = 0;
    for (int i = 0; i < N; i++) if (nz == 1 && cur[i] != 0) win = i;

    // Launch
    use_model = !forced;
    force_pu  = pf;
    @(negedge clk);
    bus.x0_in = X_W'(xi[0]);
    bus.x1_in = X_W'(xi[1]);
    bus.x2_in = X_W'(xi[2]);
    bus.x3_in = X_W'(xi[3]);
    bus.start = 1'b1;
    c = 0;
    seen = 1'b0;
    while (c < 3 * 64 + 10) begin
      @(negedge clk);
      c++;
      bus.start = (inj && c == 4);
      if (inj && c == 4) begin
        bus.x0_in = X_W'($urandom_range(X_MAX));
        bus.x1_in = X_W'($urandom_range(X_MAX));
      end
      if (c == 1) check({name, " done_drop"}, bus.done, 0);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      check({name, " traj"}, obs_x() * 2 + bus.busy, pack4(traj[(c - 1) / 3]) * 2 + 1);
    end
    bus.start = 1'b0;
    if (!seen) begin
      check({name, " done_timeout"}, 0, 1);
    end else begin
      check({name, " done_lat"}, c - 1, 3 * iters);
      check({name, " x_final"}, obs_x(), pack4(cur));
      check({name, " busy_done"}, bus.busy, 0);
      check({name, " wvld"}, bus.winner_valid, (nz == 1 && tmo == 0) ? 1 : 0);
      check({name, " winner"}, bus.winner, (tmo == 0) ? win : 0);
      check({name, " iter"}, bus.iter_cnt, iters);
`ifdef MAXNET_TIMEOUT_EN
      check({name, " timeout"}, bus.timeout, tmo);
`endif
    end
  endtask

  int xa[N], pa[N];

  initial begin
    rst = 1'b1;
    use_model = 1'b1;
    force_pu = '{0, 0, 0, 0};
    bus.start = 1'b0;
    bus.x0_in = '0; bus.x1_in = '0; bus.x2_in = '0; bus.x3_in = '0;
    repeat (3) @(negedge clk);
    check("rst x", obs_x(), 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst wvld", bus.winner_valid, 0);
    check("rst winner", bus.winner, 0);
    check("rst iter", bus.iter_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    pa = '{0, 0, 0, 0};
    xa = '{8, 4, 2, 1}; run_case("t1", xa, 0, pa, 0);
    xa = '{4, 4, 0, 0}; run_case("t2", xa, 0, pa, 0);
    xa = '{0, 0, 5, 0}; run_case("t3", xa, 0, pa, 0);
    pa = '{2047, -5, -5, -5};
    xa = '{3, 3, 3, 3}; run_case("t4", xa, 1, pa, 0);

    // Async reset in the WAIT of iteration 2
    use_model = 1'b1;
    @(negedge clk);
    bus.x0_in = 5'sd8; bus.x1_in = 5'sd4; bus.x2_in = 5'sd2; bus.x3_in = 5'sd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5 rst x", obs_x(), 0);
    check("t5 rst busy", bus.busy, 0);
    check("t5 rst iter", bus.iter_cnt, 0);
    check("t5 rst done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    pa = '{0, 0, 0, 0};
    xa = '{8, 4, 2, 1}; run_case("t5 rerun", xa, 0, pa, 1);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) xa[i] = int'($urandom_range(X_MAX));
      run_case("rnd", xa, 0, pa, (k % 4) == 1);
    end
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = int'($urandom_range(N - 1));
      for (int i = 0; i < N; i++) begin
        xa[i] = int'($urandom_range(X_MAX));
        pa[i] = (i == idx) ? int'($urandom_range(2047, 8)) : int'($urandom_range(2055)) - 2048;
      end
      run_case("rnd_unit", xa, 1, pa, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
